// File: rtl/fir_ctrl_fsm_param_if.sv
// Control bundle between the FIR sequencer and its surrounding datapath
// (input FIFO, coefficient RAM, multiplier mux, accumulators, output register).
interface fir_ctrl_fsm_param_if #(
    parameter int SEL_W  = 2,
    parameter int ADDR_W = 4
);
    logic              PushCoef;
    logic              fifo_empty;
    logic              out_ready;
    logic [SEL_W-1:0]  multiplier_mux_sel;
    logic              partialProductAccumulate_valid;
    logic              finalAccumulateRounding_en;
    logic              fifoPullOut;
    logic              coef_wr_en;
    logic [ADDR_W-1:0] coef_wr_addr;
    logic              coef_ready;
    logic              out_valid;
    logic              coef_err;
    logic              busy;
    logic [2:0]        state_dbg;

    // Output handshake: a result transfers on a cycle where out_valid and
    // out_ready are both 1; out_valid stays high and the result stays stable
    // until that cycle, and out_valid never depends combinationally on out_ready.
    modport master (
        input  PushCoef, fifo_empty, out_ready,
        output multiplier_mux_sel, partialProductAccumulate_valid,
               finalAccumulateRounding_en, fifoPullOut, coef_wr_en,
               coef_wr_addr, coef_ready, out_valid, coef_err, busy, state_dbg
    );

    modport slave (
        output PushCoef, fifo_empty, out_ready,
        input  multiplier_mux_sel, partialProductAccumulate_valid,
               finalAccumulateRounding_en, fifoPullOut, coef_wr_en,
               coef_wr_addr, coef_ready, out_valid, coef_err, busy, state_dbg
    );
endinterface

// File: rtl/fir_ctrl_fsm_param.sv
// Parametrised FIR control FSM: coefficient load, FIFO pull, NUM_PASSES MAC passes,
// final round and output handoff. Optional macro FIR_CTRL_PERF_CNT_EN adds sample/stall counters.
module fir_ctrl_fsm_param #(
    parameter int NUM_PASSES = 4,
    parameter int SEL_W      = $clog2(NUM_PASSES),
    parameter int NUM_TAPS   = 16,
    parameter int ADDR_W     = $clog2(NUM_TAPS)
) (
    input  logic clk,
    input  logic reset,
    fir_ctrl_fsm_param_if.master bus
`ifdef FIR_CTRL_PERF_CNT_EN
    ,
    output logic [15:0] sample_cnt,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PULL  = 3'd2,
        MAC   = 3'd3,
        FINAL = 3'd4,
        OUT   = 3'd5
    } state_t;

    localparam logic [SEL_W-1:0]  LAST_PASS = SEL_W'(NUM_PASSES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  pass_q, pass_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [SEL_W-1:0]  mux_sel_q, mux_sel_d;
    logic              ppav_q, ppav_d;
    logic              fin_q, fin_d;
    logic              pull_q, pull_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              coef_ready_q, coef_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              coef_err_q, coef_err_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        addr_d       = addr_q;
        coef_ready_d = coef_ready_q;
        coef_err_d   = coef_err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = '0;

        unique case (state_q)
            IDLE: begin
                // A coefficient word wins over a waiting sample.
                if (bus.PushCoef) begin
                    state_d      = LOAD;
                    wr_en_d      = 1'b1;
                    wr_addr_d    = '0;
                    addr_d       = ADDR_W'(1);
                    coef_ready_d = 1'b0;
                end else if (coef_ready_q && !bus.fifo_empty) begin
                    state_d = PULL;
                end
            end
            LOAD: begin
                if (bus.PushCoef) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    if (addr_q == LAST_ADDR) begin
                        addr_d       = '0;
                        coef_ready_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            PULL: begin
                state_d = MAC;
                pass_d  = '0;
            end
            MAC: begin
                if (pass_q == LAST_PASS) begin
                    state_d = FINAL;
                    pass_d  = '0;
                end else begin
                    pass_d = pass_q + SEL_W'(1);
                end
            end
            FINAL: state_d = OUT;
            OUT: begin
                if (bus.out_ready) begin
                    state_d = bus.fifo_empty ? IDLE : PULL;
                end
            end
            default: state_d = IDLE;
        endcase

        // Words arriving mid-sample are lost; flag it until the next reset.
        if (bus.PushCoef && (state_q inside {PULL, MAC, FINAL, OUT})) begin
            coef_err_d = 1'b1;
        end

        pull_d      = (state_d == PULL);
        ppav_d      = (state_d == MAC);
        mux_sel_d   = (state_d == MAC) ? pass_d : '0;
        fin_d       = (state_d == FINAL);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE) && (state_d != LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pass_q       <= '0;
            addr_q       <= '0;
            mux_sel_q    <= '0;
            ppav_q       <= 1'b0;
            fin_q        <= 1'b0;
            pull_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            coef_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            coef_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pass_q       <= pass_d;
            addr_q       <= addr_d;
            mux_sel_q    <= mux_sel_d;
            ppav_q       <= ppav_d;
            fin_q        <= fin_d;
            pull_q       <= pull_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            coef_ready_q <= coef_ready_d;
            out_valid_q  <= out_valid_d;
            coef_err_q   <= coef_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.multiplier_mux_sel             = mux_sel_q;
    assign bus.partialProductAccumulate_valid = ppav_q;
    assign bus.finalAccumulateRounding_en     = fin_q;
    assign bus.fifoPullOut                    = pull_q;
    assign bus.coef_wr_en                     = wr_en_q;
    assign bus.coef_wr_addr                   = wr_addr_q;
    assign bus.coef_ready                     = coef_ready_q;
    assign bus.out_valid                      = out_valid_q;
    assign bus.coef_err                       = coef_err_q;
    assign bus.busy                           = busy_q;
    assign bus.state_dbg                      = state_q;

`ifdef FIR_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt <= '0;
            stall_cnt  <= '0;
        end else if (state_q == OUT) begin
            if (bus.out_ready) begin
                if (sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
            end else begin
                if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fir_ctrl_fsm_param.md
Name: fir_ctrl_fsm_param

Overview:
Parametrised control FSM for the time-multiplexed FIR datapath. It sequences coefficient loading, input-FIFO pulls, NUM_PASSES multiplier passes per sample, partial-product accumulation, final accumulate/round and output handoff. Unlike the fixed 4-pass controller, it is generalised in pass count and tap count, and adds coefficient-load tracking and output backpressure. It sits between the input FIFO, coefficient RAM, multiplier mux, accumulators and output register.

Parameters:
NUM_PASSES, 4, multiplier passes per sample (>=2)
SEL_W, $clog2(NUM_PASSES), width of multiplier_mux_sel
NUM_TAPS, 16, coefficient words per full load (>=2)
ADDR_W, $clog2(NUM_TAPS), coefficient address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
PushCoef  in  1  coefficient word strobe, one word per cycle
fifo_empty  in  1  input FIFO empty
out_ready  in  1  downstream accepts result
multiplier_mux_sel  out  SEL_W  current pass index
partialProductAccumulate_valid  out  1  accumulate partial product this cycle
finalAccumulateRounding_en  out  1  final sum + round this cycle
fifoPullOut  out  1  pop input FIFO this cycle
coef_wr_en  out  1  coefficient RAM write enable
coef_wr_addr  out  ADDR_W  coefficient RAM write address
coef_ready  out  1  full coefficient set loaded
out_valid  out  1  result held valid for downstream
coef_err  out  1  sticky: PushCoef dropped while busy
busy  out  1  state != IDLE and state != LOAD

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, pass counter 0, coef address 0, coef_ready=0. Reset mid-sample abandons the sample; coefficients must be reloaded.
- All outputs registered (Moore decode of next state). No combinational input-to-output path.
- States: IDLE, LOAD, PULL, MAC, FINAL, OUT.
- IDLE: PushCoef=1 -> LOAD, with first word written. Else coef_ready & !fifo_empty -> PULL. PushCoef has priority over a non-empty FIFO.
- LOAD: each PushCoef cycle -> coef_wr_en=1 next cycle with coef_wr_addr = running address, then address increments. Gaps (PushCoef=0) hold state. After the write to NUM_TAPS-1: address wraps to 0, coef_ready=1, -> IDLE. Entering LOAD clears coef_ready.
- PULL: fifoPullOut=1 for exactly one cycle -> MAC.
- MAC: NUM_PASSES cycles. multiplier_mux_sel = 0..NUM_PASSES-1 and partialProductAccumulate_valid=1 on each. After the last pass -> FINAL.
- FINAL: finalAccumulateRounding_en=1 for one cycle -> OUT.
- OUT: out_valid=1, held until out_ready=1. On the acceptance cycle: !fifo_empty -> PULL (back-to-back), else -> IDLE. A pending PushCoef is handled only from IDLE.
- Throughput without stall: NUM_PASSES+3 cycles per sample. Latency from pull to out_valid: NUM_PASSES+2 cycles.
- PushCoef in PULL/MAC/FINAL/OUT: word dropped, coef_err set (sticky until reset). Coefficient state is unchanged.
- fifo_empty is sampled only in IDLE and at OUT acceptance. FIFO underflow is impossible by construction.
- multiplier_mux_sel is 0 outside MAC.

Optional Feature:
FIR_CTRL_PERF_CNT_EN: when defined, adds outputs sample_cnt[15:0] and stall_cnt[15:0].
- sample_cnt increments on each OUT acceptance.
- stall_cnt increments on each OUT cycle with out_ready=0.
- Both saturate at 16'hFFFF and clear on reset.
When undefined, neither port nor logic exists; all other behaviour is identical.

Test Plan:
- Reset then load: reset=0 for 2 cycles, release, 16 consecutive PushCoef -> coef_wr_addr 0..15 with coef_wr_en, coef_ready=1 one cycle after the 16th, state IDLE, coef_err=0.
- Single sample (NUM_PASSES=4): coef_ready=1, fifo_empty=0 for one sample, out_ready=1 -> fifoPullOut 1 cycle, mux_sel 0,1,2,3 with partialProductAccumulate_valid, finalAccumulateRounding_en 1 cycle, out_valid 1 cycle, 7 cycles total.
- Back-to-back: fifo_empty=0 for 3 samples, out_ready=1 -> fifoPullOut pulses exactly 7 cycles apart, 3 out_valid pulses, then IDLE.
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid held 5+1 cycles, no fifoPullOut meanwhile, stall_cnt=5 if FIR_CTRL_PERF_CNT_EN.
- Priority/drop: PushCoef and !fifo_empty same IDLE cycle -> LOAD entered, no pull. PushCoef during MAC -> coef_err=1, no coef_wr_en, pass sequence unaffected.
- Async reset mid-MAC (pass 2): all outputs 0 immediately, coef_ready=0. No fifoPullOut until coefficients are reloaded.
